// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for booth_op_sequencer and booth_op_fifo.
//   seq_state_t : sequencer FSM states (IDLE/ISSUE/WAIT/HOLD)
//   DEF_N       : default operand width
//   DEF_DEPTH   : default operand FIFO depth
//   ptr_width() : FIFO pointer width for a given depth
package booth_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } seq_state_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: DEPTH x W synchronous FIFO, first-word fall-through read.
//   clk, rst : rising-edge clock, synchronous active-high reset (clears pointers/count)
//   push     : write din (accepted when not full, or when full and popping)
//   pop      : drop head entry (ignored when empty)
//   din      : write data
//   dout     : head entry (valid when !empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int unsigned W     = 2 * DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: streaming front end for booth_multiplier_full.
// Buffers signed operand pairs in a FIFO, issues one multiply at a time with a
// start/done handshake and returns products in issue order.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : operand pair handshake (in_ready low during post-reset guard)
//   in_a, in_b        : signed multiplicand / multiplier
//   mul_start         : one-cycle start pulse to the multiplier
//   mul_multiplicand  : head operand A, stable from ISSUE through WAIT
//   mul_multiplier    : head operand B, stable from ISSUE through WAIT
//   mul_product       : multiplier product
//   mul_done          : multiplier done level (rising edge ends the operation)
//   out_valid/out_ready : result handshake
//   out_product       : registered 2N-bit signed product
//   err_timeout       : sticky abort flag
// Optional feature: define BOOTH_SEQ_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
// cycles (sets err_timeout, drops the operation). Without it err_timeout is 0.
module booth_op_sequencer
    import booth_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned GUARD   = N + 4,
    parameter int unsigned TIMEOUT = 4 * N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_start,
    output logic [N-1:0]   mul_multiplicand,
    output logic [N-1:0]   mul_multiplier,
    input  logic [2*N-1:0] mul_product,
    input  logic           mul_done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic           err_timeout
);

    localparam int unsigned PW = ptr_width(DEPTH);
    // Guard and WAIT counters share one width wide enough for either limit.
    localparam int unsigned CW = $clog2(((GUARD > TIMEOUT) ? GUARD : TIMEOUT) + 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [PW:0]   FULL_C  = (PW+1)'(DEPTH);

    seq_state_t     state;
    seq_state_t     state_nxt;
    logic           fifo_push;
    logic           fifo_pop;
    logic [2*N-1:0] fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PW:0]    fifo_count;
    logic [PW:0]    count_nxt;
    logic [CW-1:0]  guard_cnt;
    logic           guard_ok;
    logic           done_q;
    logic           first_wait;
    logic           done_edge;
    logic           capture;
    logic           timeout_hit;

    booth_op_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_push = in_valid && in_ready && (!fifo_full || fifo_pop);
    assign count_nxt = fifo_count + (PW+1)'(fifo_push) - (PW+1)'(fifo_pop);
    assign guard_ok  = (guard_cnt == GUARD_C);
    // first_wait masks a done level left over from before this operation.
    assign done_edge = mul_done && !done_q && !first_wait;

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        mul_start = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (guard_ok && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            guard_cnt        <= '0;
            done_q           <= 1'b0;
            first_wait       <= 1'b0;
            in_ready         <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
        end else begin
            state      <= state_nxt;
            done_q     <= mul_done;
            first_wait <= (state == ISSUE);
            if (!guard_ok) begin
                guard_cnt <= guard_cnt + 1'b1;
            end
            // Registered from the next count so in_ready is exactly !full.
            in_ready <= guard_ok && (count_nxt != FULL_C);
            if (fifo_pop) begin
                {mul_multiplicand, mul_multiplier} <= fifo_dout;
            end
            if (capture) begin
                out_product <= mul_product;
                out_valid   <= 1'b1;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if ((state == WAIT) && !done_edge && timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Directed bench for booth_op_sequencer with a behavioural multiplier that
// raises done (level) LAT cycles after each start and clears it on the next start.
module tb_booth_op_sequencer;

    localparam int unsigned N       = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned GUARD   = N + 4;
    localparam int unsigned TIMEOUT = 4 * N;
    localparam int unsigned LAT     = N + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_a = '0;
    logic [N-1:0]   in_b = '0;
    logic           mul_start;
    logic [N-1:0]   mul_multiplicand;
    logic [N-1:0]   mul_multiplier;
    logic [2*N-1:0] mul_product = '0;
    logic           mul_done = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] out_product;
    logic           err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*N-1:0]    got[$];
    int                starts = 0;
    bit                busy = 1'b0;
    bit                overlap_seen = 1'b0;
    bit                no_done = 1'b0;
    int                mcnt = 0;
    logic signed [31:0] ma;
    logic signed [31:0] mb;

    always #5 clk = ~clk;

    booth_op_sequencer #(
        .N       (N),
        .DEPTH   (DEPTH),
        .GUARD   (GUARD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .err_timeout      (err_timeout)
    );

    // Multiplier model, driven on the falling edge.
    always @(negedge clk) begin
        if (mul_start) begin
            if (busy) overlap_seen = 1'b1;
            starts++;
            mul_done = 1'b0;
            ma = $signed(mul_multiplicand);
            mb = $signed(mul_multiplier);
            mul_product = ma * mb;
            busy = !no_done;
            mcnt = LAT;
        end else if (busy) begin
            mcnt--;
            if (mcnt == 0) begin
                mul_done = 1'b1;
                busy = 1'b0;
            end
        end
    end

    // Result monitor: samples 1 ns before the rising edge that completes a handshake.
    always begin
        @(negedge clk);
        #4;
        if (out_valid && out_ready) got.push_back(out_product);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running, required finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds in_valid until the registered in_ready lets the push through.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && k < 1000) begin
            tick(1);
            k++;
        end
        chk_bit("push_accept", in_ready, 1'b1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk_word("result_count", got.size(), n);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!mul_start && k < 200) begin
            tick(1);
            k++;
        end
        chk_bit("start_seen", mul_start, 1'b1);
    endtask

    initial begin
        int k;
        int s0;

        // Reset state
        tick(3);
        chk_bit ("rst_in_ready",  in_ready,    1'b0);
        chk_bit ("rst_out_valid", out_valid,   1'b0);
        chk_word("rst_product",   out_product, 32'd0);
        chk_bit ("rst_start",     mul_start,   1'b0);
        chk_bit ("rst_err",       err_timeout, 1'b0);
        chk_word("rst_opa",       32'(mul_multiplicand), 32'd0);
        chk_word("rst_opb",       32'(mul_multiplier),   32'd0);
        rst = 1'b0;
        tick(GUARD - 2);
        chk_bit("guard_in_ready_low", in_ready, 1'b0);
        tick(4);
        chk_bit("guard_in_ready_high", in_ready, 1'b1);

        // 1: single operation, latency, result held until out_ready
        out_ready = 1'b0;
        push(16'sd7, 16'sd3);
        chk_bit ("t1_lat_t1", mul_start, 1'b0);
        tick(1);
        chk_bit ("t1_lat_t2", mul_start, 1'b1);
        chk_word("t1_opa", 32'(mul_multiplicand), 32'd7);
        chk_word("t1_opb", 32'(mul_multiplier),   32'd3);
        tick(1);
        chk_bit ("t1_one_pulse", mul_start, 1'b0);
        k = 0;
        while (!out_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk_bit ("t1_valid", out_valid, 1'b1);
        chk_word("t1_product", out_product, 32'd21);
        tick(10);
        chk_bit ("t1_valid_held", out_valid, 1'b1);
        chk_word("t1_product_held", out_product, 32'd21);
        chk_word("t1_starts", starts, 32'd1);
        out_ready = 1'b1;
        tick(1);
        chk_bit ("t1_release", out_valid, 1'b0);
        chk_word("t1_got0", got[0], 32'd21);

        // 2: back-to-back operands, in-order products
        push(16'sd12, -16'sd5);
        push(-16'sd9, -16'sd4);
        push(-16'sd32768, -16'sd32768);
        wait_got(4, 400);
        chk_word("t2_p0", got[1], -32'sd60);
        chk_word("t2_p1", got[2], 32'd36);
        chk_word("t2_p2", got[3], 32'd1073741824);
        chk_word("t2_starts", starts, 32'd4);
        chk_bit ("t2_no_overlap", overlap_seen, 1'b0);

        // 3: consumer stalled, FIFO fills to DEPTH plus the issued one
        out_ready = 1'b0;
        push(16'sd1, 16'sd2);
        push(-16'sd3, 16'sd4);
        push(16'sd100, -16'sd100);
        push(16'sd32767, 16'sd32767);
        push(-16'sd1, -16'sd32768);
        tick(2);
        chk_bit("t3_full_in_ready", in_ready, 1'b0);
        tick(20);
        chk_bit ("t3_still_full", in_ready, 1'b0);
        chk_word("t3_no_drain", got.size(), 32'd4);
        out_ready = 1'b1;
        wait_got(9, 800);
        chk_word("t3_p0", got[4], 32'd2);
        chk_word("t3_p1", got[5], -32'sd12);
        chk_word("t3_p2", got[6], -32'sd10000);
        chk_word("t3_p3", got[7], 32'd1073676289);
        chk_word("t3_p4", got[8], 32'd32768);

        // 5: full FIFO with pointers wrapped, pushes waiting on the pop
        out_ready = 1'b0;
        push(16'sd2, 16'sd3);
        push(-16'sd4, 16'sd5);
        push(16'sd7, -16'sd8);
        push(-16'sd9, -16'sd10);
        push(16'sd11, 16'sd12);
        tick(2);
        chk_bit("t5_full", in_ready, 1'b0);
        out_ready = 1'b1;
        push(16'sd13, -16'sd14);
        push(-16'sd15, 16'sd16);
        wait_got(16, 1200);
        chk_word("t5_p0", got[9],  32'd6);
        chk_word("t5_p1", got[10], -32'sd20);
        chk_word("t5_p2", got[11], -32'sd56);
        chk_word("t5_p3", got[12], 32'd90);
        chk_word("t5_p4", got[13], 32'd132);
        chk_word("t5_p5", got[14], -32'sd182);
        chk_word("t5_p6", got[15], -32'sd240);
        chk_bit ("t5_no_overlap", overlap_seen, 1'b0);

        // 4: reset while a multiply is in WAIT and another operand is queued
        push(16'sd5, 16'sd6);
        wait_start();
        push(16'sd8, 16'sd9);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_bit ("t4_rst_valid", out_valid, 1'b0);
        chk_bit ("t4_rst_in_ready", in_ready, 1'b0);
        chk_word("t4_rst_opa", 32'(mul_multiplicand), 32'd0);
        rst = 1'b0;
        s0 = starts;
        tick(GUARD);
        chk_word("t4_guard_no_start", starts, s0);
        chk_bit ("t4_stale_done_seen", mul_done, 1'b1);
        tick(30);
        chk_word("t4_flushed", starts, s0);
        chk_word("t4_no_stale_result", got.size(), 32'd16);
        chk_bit ("t4_valid_low", out_valid, 1'b0);
        push(-16'sd7, 16'sd6);
        wait_got(17, 200);
        chk_word("t4_after_rst", got[16], -32'sd42);
        chk_word("t4_starts", starts, s0 + 1);

`ifdef BOOTH_SEQ_TIMEOUT_EN
        // 6: multiplier never finishes
        no_done = 1'b1;
        push(16'sd3, 16'sd3);
        wait_start();
        tick(TIMEOUT - 2);
        chk_bit("t6_err_before", err_timeout, 1'b0);
        tick(5);
        chk_bit ("t6_err_set", err_timeout, 1'b1);
        chk_word("t6_no_result", got.size(), 32'd17);
        no_done = 1'b0;
        push(16'sd4, 16'sd4);
        wait_got(18, 200);
        chk_word("t6_next_product", got[17], 32'd16);
        chk_bit ("t6_err_sticky", err_timeout, 1'b1);
`endif

        chk_bit("final_no_overlap", overlap_seen, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
